// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-path constants and the buffered fetch entry type
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0] pc_next;
  } fetch_entry_t;
  localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP, pc_next: 32'h0};
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry synchronous FIFO of fetch entries; clear beats push and pop
module fetch_buf
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  fetch_entry_t               din,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk) begin
    if (clear) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // an empty buffer presents a NOP with zero pc_next
  always_comb head = (count == '0) ? EMPTY_ENTRY : mem[rd];
  assert property (@(posedge clk) !(push && !pop && !clear && count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and fetch buffer feeding IF/ID under valid/ready
// FETCH_STATS_EN adds stat_fetched/stat_stall counters
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_next,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall,
`endif
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] pc, issued_pc;
  logic inflight, run, pop;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t head;
  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .push(inflight),
    .pop(pop),
    .clear(rst | redirect_valid),
    .din('{instr: imem_rdata, pc_next: issued_pc + PC_INC}),
    .count(count),
    .head(head)
  );
  assign if_valid = count != '0;
  assign if_instr = head.instr;
  assign if_pc_next = head.pc_next;
  assign pop = if_valid & id_ready;
  assign imem_addr = pc;
  // slots already promised: buffered words surviving this cycle plus the word in flight
  assign occ = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight};
  // run holds issue off for the first cycle after reset
  assign imem_en = !rst & run & !redirect_valid & (occ < (CW+1)'(DEPTH));
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      issued_pc <= '0;
      inflight <= 1'b0;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      inflight <= imem_en;
      if (imem_en) issued_pc <= pc;
      pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : imem_en ? pc + PC_INC : pc;
    end
  end
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_stall <= '0;
    end else begin
      stat_fetched <= stat_fetched + 32'(pop);
      stat_stall <= stat_stall + 32'(if_valid & !id_ready);
    end
  end
`endif
endmodule
